// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer for the 8-bit CPU; fetches a 16-bit
// instruction as two bytes, decodes it and runs 0-3 execute cycles.
// Ports: clock/reset (sync, active-high); ir_out, latch_flags, mem_ready in;
// memory strobes, address select, PC, register-file, ALU, latch, MAR/IR/JR
// byte-load strobes and halted out.
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [15:0] ir_out,
  input  logic [2:0] latch_flags,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       reg_load,
  output logic       reg_enable,
  output logic [1:0] reg_in_regselect,
  output logic [1:0] reg_out_regselect,
  output logic [1:0] reg_alu_regselect,
  output logic [3:0] alu_operation,
  output logic       latch_grab,
  output logic       latch_store,
  output logic       mar_high,
  output logic       mar_low,
  output logic       ir_high,
  output logic       ir_low,
  output logic       jr_high,
  output logic       jr_low,
  output logic       halted
);

  typedef enum logic [2:0] {
    FETCH_H, FETCH_L, DECODE, E1, E2, E3, HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ALU = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JCC = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state, state_nxt;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] aluop;
  logic       take;
  logic       unused_ir_lsb;

  assign op            = ir_out[15:12];
  assign rd            = ir_out[11:10];
  assign rs            = ir_out[9:8];
  assign aluop         = ir_out[7:4];
  assign unused_ir_lsb = ^ir_out[3:0];

  // Condition select: 0..2 pick a flag, 3 is the never-taken encoding.
  always_comb begin
    take = 1'b0;
    case (rs)
      2'd0:    take = latch_flags[0];
      2'd1:    take = latch_flags[1];
      2'd2:    take = latch_flags[2];
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH_H;
    else       state <= state_nxt;
  end

  // In memory states the state holds and every load/inc strobe is suppressed
  // until mem_ready, so a stalled access never repeats a PC increment.
  // Selects stay valid during the stall so the datapath sees a stable setup.
  always_comb begin
    state_nxt         = state;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    addr_sel          = 1'b0;
    pc_inc            = 1'b0;
    pc_load           = 1'b0;
    reg_load          = 1'b0;
    reg_enable        = 1'b0;
    reg_in_regselect  = 2'd0;
    reg_out_regselect = 2'd0;
    reg_alu_regselect = 2'd0;
    alu_operation     = 4'd0;
    latch_grab        = 1'b0;
    latch_store       = 1'b0;
    mar_high          = 1'b0;
    mar_low           = 1'b0;
    ir_high           = 1'b0;
    ir_low            = 1'b0;
    jr_high           = 1'b0;
    jr_low            = 1'b0;
    halted            = 1'b0;

    // Outputs are forced quiet while reset is held, even mid-instruction.
    if (!reset) begin
      case (state)
        FETCH_H: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_high   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = FETCH_L;
          end
        end
        FETCH_L: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_low    = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = DECODE;
          end
        end
        DECODE: begin
          case (op)
            OP_MOV, OP_LDI, OP_ALU, OP_LD, OP_ST, OP_JMP, OP_JCC: state_nxt = E1;
            OP_HLT:  state_nxt = HALT;
            default: state_nxt = FETCH_H;  // NOP and undefined opcodes
          endcase
        end
        E1: begin
          state_nxt = FETCH_H;
          case (op)
            OP_MOV: begin
              reg_enable        = 1'b1;
              reg_out_regselect = rs;
              reg_load          = 1'b1;
              reg_in_regselect  = rd;
            end
            OP_LDI: begin
              mem_read         = 1'b1;
              reg_in_regselect = rd;
              state_nxt        = E1;
              if (mem_ready) begin
                reg_load  = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = FETCH_H;
              end
            end
            OP_ALU: begin
              reg_enable        = 1'b1;
              reg_out_regselect = rs;
              reg_alu_regselect = rd;
              alu_operation     = aluop;
              latch_grab        = 1'b1;
              state_nxt         = E2;
            end
            OP_LD, OP_ST, OP_JMP, OP_JCC: begin
              mem_read  = 1'b1;
              state_nxt = E1;
              if (mem_ready) begin
                mar_high  = (op == OP_LD) || (op == OP_ST);
                jr_high   = (op == OP_JMP) || (op == OP_JCC);
                pc_inc    = 1'b1;
                state_nxt = E2;
              end
            end
            default: state_nxt = FETCH_H;
          endcase
        end
        E2: begin
          state_nxt = FETCH_H;
          case (op)
            OP_ALU: begin
              latch_store      = 1'b1;
              reg_load         = 1'b1;
              reg_in_regselect = rd;
            end
            OP_LD, OP_ST, OP_JMP, OP_JCC: begin
              mem_read  = 1'b1;
              state_nxt = E2;
              if (mem_ready) begin
                mar_low   = (op == OP_LD) || (op == OP_ST);
                jr_low    = (op == OP_JMP) || (op == OP_JCC);
                pc_inc    = 1'b1;
                state_nxt = E3;
              end
            end
            default: state_nxt = FETCH_H;
          endcase
        end
        E3: begin
          state_nxt = FETCH_H;
          case (op)
            OP_LD: begin
              mem_read         = 1'b1;
              addr_sel         = 1'b1;
              reg_in_regselect = rd;
              state_nxt        = E3;
              if (mem_ready) begin
                reg_load  = 1'b1;
                state_nxt = FETCH_H;
              end
            end
            OP_ST: begin
              reg_enable        = 1'b1;
              reg_out_regselect = rs;
              mem_write         = 1'b1;
              addr_sel          = 1'b1;
              state_nxt         = mem_ready ? FETCH_H : E3;
            end
            OP_JMP:  pc_load = 1'b1;
            OP_JCC:  pc_load = take;
            default: state_nxt = FETCH_H;
          endcase
        end
        HALT: begin
          halted = 1'b1;
        end
        default: state_nxt = FETCH_H;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-bit microprocessor. It sits directly upstream of the datapath. It consumes the datapath's instruction register and ALU latch flags, and generates every datapath control strobe plus the memory read/write handshake. It is a multi-cycle Moore FSM: it fetches a 16-bit instruction as two bytes, decodes it, and runs 0–3 execute cycles.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces FETCH_H
- ir_out  in  16  instruction from datapath: op=[15:12], rd=[11:10], rs/cond=[9:8], aluop=[7:4]
- latch_flags  in  3  {neg, carry, zero} = bits [2:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- mem_read, mem_write  out  1  memory strobes (memory drives/samples databus)
- addr_sel  out  1  0 = address from pc_out, 1 = from mar_out
- pc_inc, pc_load  out  1  program counter controls
- reg_load, reg_enable  out  1  register file write / drive-databus
- reg_in_regselect, reg_out_regselect, reg_alu_regselect  out  2 each
- alu_operation  out  4
- latch_grab, latch_store  out  1  capture ALU result+flags / drive result onto databus
- mar_high, mar_low, ir_high, ir_low, jr_high, jr_low  out  1  byte loads from databus
- halted  out  1  high in HALT

## Operation
- States: FETCH_H, FETCH_L, DECODE, E1, E2, E3, HALT.
- FETCH_H/FETCH_L: mem_read=1, addr_sel=0. When mem_ready=1, assert ir_high (resp. ir_low) and pc_inc, then advance.
- DECODE: no strobes. Next state is E1, except: NOP or an undefined opcode goes to FETCH_H; HLT goes to HALT.
- Memory rule: in any state with mem_read or mem_write set, the state holds until mem_ready=1. Every load/inc/pc strobe in that state is gated by mem_ready, so a wait never double-increments PC.
- Bus rule: at most one of reg_enable, latch_store, mem_read drives databus in a cycle.
- Opcodes:
  - 0x0 NOP: no execute cycles.
  - 0x1 MOV rd←rs (E1): reg_enable with reg_out_regselect=rs; reg_load with reg_in_regselect=rd.
  - 0x2 LDI rd←byte@PC (E1): mem_read, addr_sel=0; on ready, reg_load rd and pc_inc.
  - 0x3 ALU rd←rd op rs:
    - E1: reg_enable rs, reg_alu_regselect=rd, alu_operation=aluop, latch_grab.
    - E2: latch_store, reg_load rd.
  - 0x4 LD rd←[addr16]:
    - E1, E2: read PC bytes into mar_high then mar_low, pc_inc each.
    - E3: mem_read, addr_sel=1, reg_load rd.
  - 0x5 ST [addr16]←rs:
    - E1, E2: as LD.
    - E3: reg_enable rs, mem_write, addr_sel=1.
  - 0x6 JMP addr16:
    - E1, E2: read PC bytes into jr_high, jr_low, pc_inc each.
    - E3: pc_load.
  - 0x7 Jcc addr16: same as JMP, but E3 asserts pc_load only if latch_flags[cond] is 1. cond=3 is never taken. Operand bytes are always consumed.
  - 0xF HLT: enter HALT; all strobes 0, halted=1 until reset.
- When an instruction finishes its last execute cycle, the next state is FETCH_H.
- Unused selects and alu_operation output 0 when not in use.

## Timing
- Reset: state=FETCH_H next cycle. While reset=1 all outputs are 0, including halted and mem_read. Reset mid-instruction abandons it with no further strobes.
- Outputs are combinational from the state register and ir_out only; no dependence on databus. Exception: the mem_ready gating of strobes in memory states is combinational from mem_ready.
- A strobe asserted in cycle N takes effect at the datapath edge ending cycle N.
- Zero-wait cycle counts (fetch+decode = 3): NOP 3, MOV 4, LDI 4, ALU 5, LD/ST/JMP/Jcc 6.
- Each cycle of mem_ready=0 in a memory state adds exactly one cycle.
- Jcc samples latch_flags in E3. Flags are therefore those of the last latch_grab.
- A read and a write are never asserted in the same cycle.

## Test plan
- Reset, then IR=0x1600 (MOV r1←r2), mem_ready=1 → sequence FETCH_H, FETCH_L, DECODE, E1. In E1: reg_enable=1, reg_out_regselect=2, reg_load=1, reg_in_regselect=1. Next cycle is FETCH_H.
- IR=0x3420 (ALU r1←r1 op2 r0) → E1: latch_grab=1, alu_operation=2, reg_alu_regselect=1, reg_out_regselect=0. E2: latch_store=1, reg_load=1, reg_in_regselect=1. Exactly 2 execute cycles.
- IR=0x4C00 (LD r3), mem_ready low for 2 cycles in E3 → mem_read and addr_sel=1 held 3 cycles. reg_load pulses only on the ready cycle. pc_inc total over the instruction = 4.
- IR=0x7100 (Jcc carry): with flags=3'b010, pc_load=1 in E3; with flags=3'b000, pc_load=0 in E3. Both cases give pc_inc count 4 and 6 cycles.
- IR=0xF000 → halted=1 from the cycle after DECODE; no strobes for 20 cycles. reset=1 → FETCH_H, halted=0.
- Assert reset during E2 of ST → no mem_write is ever issued; all outputs 0 while reset is high.
